// File: rtl/padlock_sequencer.sv
// padlock_sequencer: 4-digit BCD keypad lock with a timed unlock window.
// Define PADLOCK_ATTEMPT_LIMIT_EN to build the failed-attempt lockout.
module padlock_sequencer #(
  parameter logic [15:0] CODE           = 16'h1357,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          OPEN_CYCLES    = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       open,
  output logic       lock,
  output logic       lockout,
  output logic [2:0] fail_count,
  output logic [2:0] digit_count
);

  localparam int MAX_DUR = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_DUR + 1);

  localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;

  state_t           state_r;
  logic [15:0]      entry_r;
  logic [CNT_W-1:0] cnt_r;

`ifdef PADLOCK_ATTEMPT_LIMIT_EN
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]       TRY_LIMIT = 3'(MAX_TRIES);
  logic lockout_r;
  assign lockout = lockout_r;
`else
  assign lockout = 1'b0;
`endif

  // Keypad FSM: digit capture, code check, timed unlock/lockout windows
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ENTRY;
      lock        <= 1'b1;
      fail_count  <= 3'd0;
      digit_count <= 3'd0;
      entry_r     <= 16'h0000;
      cnt_r       <= CNT_ZERO;
`ifdef PADLOCK_ATTEMPT_LIMIT_EN
      lockout_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ENTRY: begin
          if (open) begin
            digit_count <= 3'd0;
            entry_r     <= 16'h0000;
            if ((digit_count == 3'd4) && (entry_r == CODE)) begin
              state_r    <= UNLOCKED;
              lock       <= 1'b0;
              fail_count <= 3'd0;
              cnt_r      <= OPEN_LOAD;
            end else begin
`ifdef PADLOCK_ATTEMPT_LIMIT_EN
              fail_count <= fail_count + 3'd1;
              if ((fail_count + 3'd1) == TRY_LIMIT) begin
                state_r   <= LOCKOUT;
                lockout_r <= 1'b1;
                cnt_r     <= LOCK_LOAD;
              end
`else
              if (fail_count != 3'd7) begin
                fail_count <= fail_count + 3'd1;
              end
`endif
            end
          end else if (digit_valid && (digit <= 4'd9) && (digit_count != 3'd4)) begin
            entry_r     <= {entry_r[11:0], digit};
            digit_count <= digit_count + 3'd1;
          end
        end
        UNLOCKED: begin
          if (cnt_r == CNT_ZERO) begin
            state_r <= ENTRY;
            lock    <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
`ifdef PADLOCK_ATTEMPT_LIMIT_EN
        LOCKOUT: begin
          if (cnt_r == CNT_ZERO) begin
            state_r    <= ENTRY;
            lockout_r  <= 1'b0;
            fail_count <= 3'd0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
`endif
        default: begin
          // Unreachable encodings fall back to a safe locked entry state
          state_r     <= ENTRY;
          lock        <= 1'b1;
          fail_count  <= 3'd0;
          digit_count <= 3'd0;
          entry_r     <= 16'h0000;
          cnt_r       <= CNT_ZERO;
`ifdef PADLOCK_ATTEMPT_LIMIT_EN
          lockout_r   <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_padlock_sequencer.sv
// Table-driven scoreboard bench for padlock_sequencer (CODE 1357, 3 tries,
// 8-cycle lockout, 4-cycle unlock); lockout checks follow PADLOCK_ATTEMPT_LIMIT_EN.
module tb_padlock_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] digit;
  logic       digit_valid;
  logic       open;
  logic       lock;
  logic       lockout;
  logic [2:0] fail_count;
  logic [2:0] digit_count;

  typedef struct {
    logic       rst_n;
    logic       dv;
    logic [3:0] d;
    logic       op;
    logic       e_lock;
    logic       e_lko;
    logic [2:0] e_fc;
    logic [2:0] e_dc;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] val;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  padlock_sequencer #(
    .CODE(16'h1357),
    .MAX_TRIES(3),
    .LOCKOUT_CYCLES(8),
    .OPEN_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .digit(digit),
    .digit_valid(digit_valid),
    .open(open),
    .lock(lock),
    .lockout(lockout),
    .fail_count(fail_count),
    .digit_count(digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic rst_n, input logic dv, input logic [3:0] d,
                              input logic op, input logic e_lock, input logic e_lko,
                              input logic [2:0] e_fc, input logic [2:0] e_dc);
    vec_t v;
    v = '{rst_n, dv, d, op, e_lock, e_lko, e_fc, e_dc};
    vecs.push_back(v);
  endfunction

  function automatic void rst();
    add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
  endfunction

  function automatic void dig(input logic [3:0] d, input logic [2:0] fc, input logic [2:0] dc);
    add(1'b1, 1'b1, d, 1'b0, 1'b1, 1'b0, fc, dc);
  endfunction

  function automatic void opn(input logic e_lock, input logic e_lko, input logic [2:0] fc);
    add(1'b1, 1'b0, 4'd0, 1'b1, e_lock, e_lko, fc, 3'd0);
  endfunction

  function automatic void idle(input logic e_lock, input logic e_lko,
                               input logic [2:0] fc, input logic [2:0] dc);
    add(1'b1, 1'b0, 4'd0, 1'b0, e_lock, e_lko, fc, dc);
  endfunction

  // Monitor: pop the expectation for each edge and compare just after it
  always @(posedge clk) begin
    exp_t       e;
    logic [7:0] act;
    #1;
    if (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      act = {lock, lockout, fail_count, digit_count};
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL vec%0d: got lock=%0b lockout=%0b fail=%0d dc=%0d, want lock=%0b lockout=%0b fail=%0d dc=%0d",
                 e.idx, act[7], act[6], act[5:3], act[2:0], e.val[7], e.val[6], e.val[5:3], e.val[2:0]);
      end
    end
  end

  initial begin
    reset       = 1'b0;
    digit       = 4'd0;
    digit_valid = 1'b0;
    open        = 1'b0;

    // Reset state
    rst(); rst();
    // Correct code: unlocked for exactly 4 cycles
    dig(4'd1, 3'd0, 3'd1); dig(4'd3, 3'd0, 3'd2); dig(4'd5, 3'd0, 3'd3); dig(4'd7, 3'd0, 3'd4);
    opn(1'b0, 1'b0, 3'd0);
    idle(1'b0, 1'b0, 3'd0, 3'd0); idle(1'b0, 1'b0, 3'd0, 3'd0); idle(1'b0, 1'b0, 3'd0, 3'd0);
    idle(1'b1, 1'b0, 3'd0, 3'd0);
    // Digit and open together: open wins, digit dropped
    rst();
    dig(4'd1, 3'd0, 3'd1); dig(4'd3, 3'd0, 3'd2); dig(4'd5, 3'd0, 3'd3);
    add(1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 3'd1, 3'd0);
    idle(1'b1, 1'b0, 3'd1, 3'd0);
    // Short entry is a failure
    dig(4'd1, 3'd1, 3'd1); opn(1'b1, 1'b0, 3'd2);
    // Non-BCD and fifth digit ignored, then unlock; keys ignored while unlocked
    rst();
    dig(4'd1, 3'd0, 3'd1); dig(4'd12, 3'd0, 3'd1); dig(4'd3, 3'd0, 3'd2); dig(4'd5, 3'd0, 3'd3);
    dig(4'd7, 3'd0, 3'd4); dig(4'd9, 3'd0, 3'd4);
    opn(1'b0, 1'b0, 3'd0);
    add(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    add(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    idle(1'b0, 1'b0, 3'd0, 3'd0);
    idle(1'b1, 1'b0, 3'd0, 3'd0);
    dig(4'd2, 3'd0, 3'd1);
    // Reset at cycle 2 of UNLOCKED
    rst();
    dig(4'd1, 3'd0, 3'd1); dig(4'd3, 3'd0, 3'd2); dig(4'd5, 3'd0, 3'd3); dig(4'd7, 3'd0, 3'd4);
    opn(1'b0, 1'b0, 3'd0);
    idle(1'b0, 1'b0, 3'd0, 3'd0);
    rst();
    idle(1'b1, 1'b0, 3'd0, 3'd0); idle(1'b1, 1'b0, 3'd0, 3'd0);
    dig(4'd4, 3'd0, 3'd1);
    // Repeated wrong code
    rst();
    for (int t = 0; t < 2; t++) begin
      dig(4'd1, 3'(t), 3'd1); dig(4'd3, 3'(t), 3'd2); dig(4'd5, 3'(t), 3'd3); dig(4'd6, 3'(t), 3'd4);
      opn(1'b1, 1'b0, 3'(t + 1));
    end
    dig(4'd1, 3'd2, 3'd1); dig(4'd3, 3'd2, 3'd2); dig(4'd5, 3'd2, 3'd3); dig(4'd6, 3'd2, 3'd4);
`ifdef PADLOCK_ATTEMPT_LIMIT_EN
    opn(1'b1, 1'b1, 3'd3);
    // Correct code during lockout is ignored; lockout lasts exactly 8 cycles
    add(1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0);
    add(1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0);
    add(1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0);
    add(1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0);
    opn(1'b1, 1'b1, 3'd3);
    idle(1'b1, 1'b1, 3'd3, 3'd0); idle(1'b1, 1'b1, 3'd3, 3'd0);
    idle(1'b1, 1'b0, 3'd0, 3'd0);
    dig(4'd1, 3'd0, 3'd1); dig(4'd3, 3'd0, 3'd2); dig(4'd5, 3'd0, 3'd3); dig(4'd7, 3'd0, 3'd4);
    opn(1'b0, 1'b0, 3'd0);
    idle(1'b0, 1'b0, 3'd0, 3'd0); idle(1'b0, 1'b0, 3'd0, 3'd0); idle(1'b0, 1'b0, 3'd0, 3'd0);
    idle(1'b1, 1'b0, 3'd0, 3'd0);
    // Reset releases lockout
    opn(1'b1, 1'b0, 3'd1); opn(1'b1, 1'b0, 3'd2); opn(1'b1, 1'b1, 3'd3);
    idle(1'b1, 1'b1, 3'd3, 3'd0);
    rst();
    idle(1'b1, 1'b0, 3'd0, 3'd0);
`else
    // No lockout: digits still accepted, fail_count saturates at 7
    opn(1'b1, 1'b0, 3'd3);
    dig(4'd8, 3'd3, 3'd1);
    opn(1'b1, 1'b0, 3'd4); opn(1'b1, 1'b0, 3'd5); opn(1'b1, 1'b0, 3'd6);
    opn(1'b1, 1'b0, 3'd7); opn(1'b1, 1'b0, 3'd7);
    dig(4'd1, 3'd7, 3'd1); dig(4'd3, 3'd7, 3'd2); dig(4'd5, 3'd7, 3'd3); dig(4'd7, 3'd7, 3'd4);
    opn(1'b0, 1'b0, 3'd0);
    idle(1'b0, 1'b0, 3'd0, 3'd0); idle(1'b0, 1'b0, 3'd0, 3'd0); idle(1'b0, 1'b0, 3'd0, 3'd0);
    idle(1'b1, 1'b0, 3'd0, 3'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(negedge clk);
      reset       = vecs[i].rst_n;
      digit_valid = vecs[i].dv;
      digit       = vecs[i].d;
      open        = vecs[i].op;
      e.idx = i;
      e.val = {vecs[i].e_lock, vecs[i].e_lko, vecs[i].e_fc, vecs[i].e_dc};
      sb_q.push_back(e);
    end
    @(negedge clk);
    digit_valid = 1'b0;
    open        = 1'b0;

    for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(posedge clk);
    #2;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
